unshifter: RTL and testbench
============================

// Module: unshifter
// PURPOSE
// - Inverse of the coordinate shift stage: converts centre-relative coordinates back to absolute screen coordinates.
// - Computes ABS = REL + CENTER, where REL is signed two's complement and CENTER is unsigned.
// - Sits after the relative-space processing blocks and before the framebuffer/pixel writer.
// - Two-stage valid/ready pipeline with a latched centre, an out-of-range flag and an output sample counter.
// PARAMETERS
// - W      8   coordinate width; XREL/YREL are signed, XCENTER/YCENTER/XOUT/YOUT are unsigned
// - CNT_W  16  width of the PT_CNT output-sample counter
// PORTS
// - ACLK       in   1      clock; all logic on posedge
// - ARESET     in   1      reset; asynchronous, active-high
// - ENB        in   1      global advance enable; low freezes the whole block
// - CTR_LD     in   1      strobe: capture XCENTER/YCENTER into the centre registers
// - XCENTER    in   W      new X centre (unsigned)
// - YCENTER    in   W      new Y centre (unsigned)
// - IN_VALID   in   1      input sample valid
// - IN_READY   out  1      block can accept an input sample
// - XREL       in   W      relative X (signed)
// - YREL       in   W      relative Y (signed)
// - OUT_VALID  out  1      output sample valid
// - OUT_READY  in   1      downstream accepts the output sample
// - XOUT       out  W      absolute X
// - YOUT       out  W      absolute Y
// - OOR        out  1      true sum of X or Y lies outside [0, 2^W-1]
// - PT_CNT     out  CNT_W  number of completed output handshakes
// BEHAVIOUR
// - Reset values (asynchronous, immediate):
//   - both stages empty; OUT_VALID=0, XOUT=YOUT=0, OOR=0, PT_CNT=0
//   - centre registers = 0; IN_READY=0 while ARESET is high
// - Reset mid-operation discards all in-flight samples; no output handshake completes in that cycle.
// - Handshakes: input accepted when IN_VALID&IN_READY&ENB; output completes when OUT_VALID&OUT_READY&ENB.
// - ENB=0: IN_READY=0; no register changes (centre included); OUT_VALID/XOUT/YOUT/OOR hold.
// - Stage 1 (S1): registers XREL/YREL together with a snapshot of the current centre.
// - Stage 2 (S2 = output register):
//   - computes the (W+2)-bit signed sum per axis: sext(REL) + zext(CENTER)
//   - drives XOUT/YOUT/OOR and OUT_VALID
// - Latency: 2 cycles from input accept to OUT_VALID=1 when not stalled; throughput 1 sample/cycle.
// - S2 loads when it is empty or its sample is handshaking that cycle.
// - S1 advances into S2 whenever S2 loads.
// - IN_READY = ENB & (!S1_valid | S2 loads); IN_READY is not combinationally dependent on IN_VALID.
// - Full pipeline with OUT_READY=0 holds exactly 2 samples; order preserved; no drop or duplicate.
// - CTR_LD (ENB=1) updates the centre at the clock edge; applies to samples accepted on later cycles.
//   - A sample accepted in the same cycle as CTR_LD uses the old centre.
//   - Samples already in S1/S2 keep their snapshot.
// - OOR per sample: (X sum < 0 or > 2^W-1) OR (Y sum < 0 or > 2^W-1).
// - PT_CNT: +1 per completed output handshake; wraps 2^CNT_W-1 -> 0.
// CONFIGURATION
// - Macro UNSHIFT_CLIP_EN:
//   - Defined: out-of-range axis saturates (sum<0 -> 0; sum>2^W-1 -> 2^W-1); OOR still asserted.
//   - Undefined: XOUT/YOUT = sum mod 2^W (wrap-around); OOR still asserted.
// - In-range results are identical in both builds.
// TESTING
// - Reset, ENB=1, CTR_LD with centre (100,50), then in (XREL=0xEC/-20, YREL=0x0A)
//   -> 2 cycles later XOUT=80, YOUT=60, OOR=0; PT_CNT=1 after handshake.
// - Centre (250,0), in (+10,0)
//   -> OOR=1; XOUT=4 without UNSHIFT_CLIP_EN, XOUT=255 with it.
// - Centre (5,5), in (0xF6/-10, 0)
//   -> OOR=1; XOUT=251 wrap, XOUT=0 clipped; YOUT=5.
// - OUT_READY=0, 4 back-to-back inputs
//   -> IN_READY drops after 2 accepts; raising OUT_READY yields all 4 in order; PT_CNT=4.
// - CTR_LD to (10,10) in the same cycle as accepting (1,1) with old centre (0,0), next input (1,1)
//   -> outputs (1,1) then (11,11).
// - Assert ARESET with 2 samples in flight, release
//   -> OUT_VALID=0, PT_CNT=0, centre=0 immediately; next input (3,4) -> output (3,4).

Source files
------------

// File: rtl/unshifter_if.sv
// unshifter_if: groups the handshake, centre-load and result signals of the
// unshifter block.
//   master modport: the side driving samples, centre and OUT_READY.
//   slave  modport: the unshifter itself.
// Signals:
//   ENB                 global advance enable
//   CTR_LD              centre capture strobe, with XCENTER/YCENTER (unsigned)
//   IN_VALID/IN_READY   input handshake, with XREL/YREL (signed)
//   OUT_VALID/OUT_READY output handshake, with XOUT/YOUT (unsigned) and OOR
//   PT_CNT              count of completed output handshakes
interface unshifter_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic             ENB;
    logic             CTR_LD;
    logic [W-1:0]     XCENTER;
    logic [W-1:0]     YCENTER;
    logic             IN_VALID;
    logic             IN_READY;
    logic [W-1:0]     XREL;
    logic [W-1:0]     YREL;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [W-1:0]     XOUT;
    logic [W-1:0]     YOUT;
    logic             OOR;
    logic [CNT_W-1:0] PT_CNT;

    modport master (
        output ENB, CTR_LD, XCENTER, YCENTER, IN_VALID, XREL, YREL, OUT_READY,
        input  IN_READY, OUT_VALID, XOUT, YOUT, OOR, PT_CNT
    );

    modport slave (
        input  ENB, CTR_LD, XCENTER, YCENTER, IN_VALID, XREL, YREL, OUT_READY,
        output IN_READY, OUT_VALID, XOUT, YOUT, OOR, PT_CNT
    );
endinterface

// File: rtl/unshifter.sv
// unshifter: converts centre-relative coordinates back to absolute screen
// coordinates, ABS = REL (signed) + CENTER (unsigned), through a two-stage
// valid/ready pipeline.
// Ports:
//   ACLK    clock, posedge
//   ARESET  asynchronous active-high reset
//   bus     unshifter_if.slave (handshakes, centre load, results, PT_CNT)
// Configuration macro:
//   UNSHIFT_CLIP_EN  defined: out-of-range axes saturate to 0 / 2^W-1;
//                    undefined: out-of-range axes wrap modulo 2^W.
//   OOR is raised for an out-of-range sample in both builds.
module unshifter #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    unshifter_if.slave  bus
);

    // Centre registers
    logic [W-1:0]     xctr_r, yctr_r;
    // Stage 1: relative sample plus the centre it was accepted under
    logic             s1_valid_r;
    logic [W-1:0]     s1_xrel_r, s1_yrel_r, s1_xctr_r, s1_yctr_r;
    // Stage 2: output register
    logic             s2_valid_r;
    logic [W-1:0]     xout_r, yout_r;
    logic             oor_r;
    logic [CNT_W-1:0] cnt_r;

    logic             s2_load_s, in_ready_s, in_acc_s, out_hs_s;
    logic [W+1:0]     xsum_s, ysum_s;
    logic [W-1:0]     xres_s, yres_s;
    logic             oor_s;

    // Two extra bits hold both the sign and the carry past 2^W-1.
    function automatic logic [W+1:0] axis_sum(input logic [W-1:0] rel,
                                              input logic [W-1:0] ctr);
        axis_sum = {{2{rel[W-1]}}, rel} + {2'b00, ctr};
    endfunction

`ifdef UNSHIFT_CLIP_EN
    function automatic logic [W-1:0] axis_clip(input logic [W+1:0] sum);
        if (sum[W+1]) begin
            axis_clip = {W{1'b0}};
        end else if (sum[W]) begin
            axis_clip = {W{1'b1}};
        end else begin
            axis_clip = sum[W-1:0];
        end
    endfunction
`endif

    // Handshake control; ENB low blocks every transfer so nothing moves.
    always_comb begin
        s2_load_s  = bus.ENB & (~s2_valid_r | bus.OUT_READY);
        in_ready_s = ~ARESET & bus.ENB & (~s1_valid_r | s2_load_s);
        in_acc_s   = in_ready_s & bus.IN_VALID;
        out_hs_s   = bus.ENB & s2_valid_r & bus.OUT_READY;
    end

    // Per-axis sums of the stage-1 sample and their out-of-range flag.
    always_comb begin
        xsum_s = axis_sum(s1_xrel_r, s1_xctr_r);
        ysum_s = axis_sum(s1_yrel_r, s1_yctr_r);
        // Bit W+1 set means negative; bit W set (non-negative) means > 2^W-1.
        oor_s  = xsum_s[W+1] | xsum_s[W] | ysum_s[W+1] | ysum_s[W];
`ifdef UNSHIFT_CLIP_EN
        xres_s = axis_clip(xsum_s);
        yres_s = axis_clip(ysum_s);
`else
        xres_s = xsum_s[W-1:0];
        yres_s = ysum_s[W-1:0];
`endif
    end

    // Centre capture; a same-cycle input still snapshots the old value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            xctr_r <= {W{1'b0}};
            yctr_r <= {W{1'b0}};
        end else if (bus.ENB && bus.CTR_LD) begin
            xctr_r <= bus.XCENTER;
            yctr_r <= bus.YCENTER;
        end else begin
            xctr_r <= xctr_r;
            yctr_r <= yctr_r;
        end
    end

    // Stage 1: take a new sample, or empty out when stage 2 pulls from it.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s1_valid_r <= 1'b0;
            s1_xrel_r  <= {W{1'b0}};
            s1_yrel_r  <= {W{1'b0}};
            s1_xctr_r  <= {W{1'b0}};
            s1_yctr_r  <= {W{1'b0}};
        end else if (in_acc_s) begin
            s1_valid_r <= 1'b1;
            s1_xrel_r  <= bus.XREL;
            s1_yrel_r  <= bus.YREL;
            s1_xctr_r  <= xctr_r;
            s1_yctr_r  <= yctr_r;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: output register; data only changes when a real sample arrives.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s2_valid_r <= 1'b0;
            xout_r     <= {W{1'b0}};
            yout_r     <= {W{1'b0}};
            oor_r      <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                xout_r <= xres_s;
                yout_r <= yres_s;
                oor_r  <= oor_s;
            end else begin
                oor_r  <= oor_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Completed output handshake counter, wrapping naturally.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.IN_READY  = in_ready_s;
    assign bus.OUT_VALID = s2_valid_r;
    assign bus.XOUT      = xout_r;
    assign bus.YOUT      = yout_r;
    assign bus.OOR       = oor_r;
    assign bus.PT_CNT    = cnt_r;

endmodule

// File: tb/tb_unshifter.sv
module tb_unshifter;
    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic ACLK = 1'b0;
    logic ARESET;

    unshifter_if #(.W(W), .CNT_W(CNT_W)) bus ();
    unshifter #(.W(W), .CNT_W(CNT_W)) dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       oor;
    } exp_t;

    typedef struct {
        logic [7:0] cx, cy, xr, yr, ex, ey;
        logic       eo;
    } vec_t;

    exp_t        q[$];
    logic [7:0]  seen_x[$];
    logic [7:0]  seen_y[$];
    int          checks   = 0;
    int          failures = 0;
    int          mcx      = 0;
    int          mcy      = 0;
    logic [15:0] mcnt     = 16'd0;
    vec_t        vecs[7];

    // Reference: true integer sum, then saturate or reduce modulo 256.
    function automatic logic [7:0] fold(input int s);
`ifdef UNSHIFT_CLIP_EN
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return s[7:0];
`else
        return s[7:0];
`endif
    endfunction

    function automatic exp_t ref_point(input logic [7:0] xr, input logic [7:0] yr,
                                       input int cx, input int cy);
        exp_t e;
        int   sx;
        int   sy;
        sx = int'($signed(xr)) + cx;
        sy = int'($signed(yr)) + cy;
        e.oor = (sx < 0) || (sx > 255) || (sy < 0) || (sy > 255);
        e.x = fold(sx);
        e.y = fold(sy);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: observe handshakes at the negedge, update model, check after edge.
    task automatic step(output bit acc);
        exp_t       e;
        bit         hold;
        logic       ov, oo;
        logic [7:0] xo, yo;
        @(negedge ACLK);
        acc  = 1'b0;
        hold = 1'b0;
        ov = 1'b0; oo = 1'b0; xo = 8'd0; yo = 8'd0;
        if (!ARESET) begin
            if (bus.ENB && bus.OUT_VALID && bus.OUT_READY) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0d expected=none", bus.XOUT);
                end else begin
                    e = q.pop_front();
                    check("model_x", 32'(bus.XOUT), 32'(e.x));
                    check("model_y", 32'(bus.YOUT), 32'(e.y));
                    check("model_oor", 32'(bus.OOR), 32'(e.oor));
                end
                seen_x.push_back(bus.XOUT);
                seen_y.push_back(bus.YOUT);
                mcnt++;
            end
            if (bus.ENB && bus.IN_VALID && bus.IN_READY) begin
                acc = 1'b1;
                q.push_back(ref_point(bus.XREL, bus.YREL, mcx, mcy));
            end
            if (bus.ENB && bus.CTR_LD) begin
                mcx = int'(bus.XCENTER);
                mcy = int'(bus.YCENTER);
            end
            if (!bus.ENB) begin
                hold = 1'b1;
                ov = bus.OUT_VALID; xo = bus.XOUT; yo = bus.YOUT; oo = bus.OOR;
                check("enb0_in_ready", 32'(bus.IN_READY), 32'd0);
            end
        end
        @(posedge ACLK);
        #1;
        check("pt_cnt", 32'(bus.PT_CNT), 32'(mcnt));
        if (hold) begin
            check("hold_valid", 32'(bus.OUT_VALID), 32'(ov));
            check("hold_x", 32'(bus.XOUT), 32'(xo));
            check("hold_y", 32'(bus.YOUT), 32'(yo));
            check("hold_oor", 32'(bus.OOR), 32'(oo));
        end
    endtask

    task automatic expect_out(input string name, input logic [7:0] x,
                              input logic [7:0] y, input logic o);
        bit acc;
        int n;
        n = 0;
        while (!bus.OUT_VALID && n < 20) begin
            step(acc);
            n++;
        end
        if (!bus.OUT_VALID) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=0 expected=1", name);
        end else begin
            check({name, "_x"}, 32'(bus.XOUT), 32'(x));
            check({name, "_y"}, 32'(bus.YOUT), 32'(y));
            check({name, "_oor"}, 32'(bus.OOR), 32'(o));
            step(acc);
        end
    endtask

    task automatic drain(input string name);
        bit acc;
        int n;
        bus.IN_VALID  = 1'b0;
        bus.CTR_LD    = 1'b0;
        bus.ENB       = 1'b1;
        bus.OUT_READY = 1'b1;
        n = 0;
        while ((q.size() != 0 || bus.OUT_VALID) && n < 20) begin
            step(acc);
            n++;
        end
        check({name, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic load_centre(input logic [7:0] cx, input logic [7:0] cy);
        bit acc;
        bus.CTR_LD = 1'b1; bus.XCENTER = cx; bus.YCENTER = cy;
        bus.IN_VALID = 1'b0;
        step(acc);
        bus.CTR_LD = 1'b0;
    endtask

    task automatic reset_pulse();
        ARESET = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_pt_cnt", 32'(bus.PT_CNT), 32'd0);
        check("rst_in_ready", 32'(bus.IN_READY), 32'd0);
        check("rst_xout", 32'(bus.XOUT), 32'd0);
        check("rst_oor", 32'(bus.OOR), 32'd0);
        q.delete();
        mcnt = 16'd0; mcx = 0; mcy = 0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
    endtask

    initial begin
        bit acc;
        int n, idx;
        logic [7:0] bp_x[4];

`ifdef UNSHIFT_CLIP_EN
        vecs[0] = '{8'd100, 8'd50,  8'hEC, 8'h0A, 8'd80,  8'd60,  1'b0};
        vecs[1] = '{8'd250, 8'd0,   8'h0A, 8'h00, 8'd255, 8'd0,   1'b1};
        vecs[2] = '{8'd5,   8'd5,   8'hF6, 8'h00, 8'd0,   8'd5,   1'b1};
        vecs[3] = '{8'd0,   8'd0,   8'hFF, 8'h80, 8'd0,   8'd0,   1'b1};
        vecs[4] = '{8'd255, 8'd255, 8'h7F, 8'h7F, 8'd255, 8'd255, 1'b1};
`else
        vecs[0] = '{8'd100, 8'd50,  8'hEC, 8'h0A, 8'd80,  8'd60,  1'b0};
        vecs[1] = '{8'd250, 8'd0,   8'h0A, 8'h00, 8'd4,   8'd0,   1'b1};
        vecs[2] = '{8'd5,   8'd5,   8'hF6, 8'h00, 8'd251, 8'd5,   1'b1};
        vecs[3] = '{8'd0,   8'd0,   8'hFF, 8'h80, 8'd255, 8'd128, 1'b1};
        vecs[4] = '{8'd255, 8'd255, 8'h7F, 8'h7F, 8'd126, 8'd126, 1'b1};
`endif
        vecs[5] = '{8'd128, 8'd128, 8'h7F, 8'h80, 8'd255, 8'd0,   1'b0};
        vecs[6] = '{8'd0,   8'd255, 8'h00, 8'h00, 8'd0,   8'd255, 1'b0};

        ARESET = 1'b1;
        bus.ENB = 1'b1; bus.CTR_LD = 1'b0; bus.XCENTER = 8'd0; bus.YCENTER = 8'd0;
        bus.IN_VALID = 1'b0; bus.XREL = 8'd0; bus.YREL = 8'd0; bus.OUT_READY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        reset_pulse();

        // Table-driven single samples with latency check.
        for (int i = 0; i < 7; i++) begin
            load_centre(vecs[i].cx, vecs[i].cy);
            bus.IN_VALID = 1'b1; bus.XREL = vecs[i].xr; bus.YREL = vecs[i].yr;
            step(acc);
            check("vec_accept", 32'(acc), 32'd1);
            bus.IN_VALID = 1'b0;
            check("vec_lat1", 32'(bus.OUT_VALID), 32'd0);
            step(acc);
            check("vec_lat2", 32'(bus.OUT_VALID), 32'd1);
            expect_out($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].eo);
            if (i == 0) check("first_pt_cnt", 32'(bus.PT_CNT), 32'd1);
        end

        // Back-pressure: two samples fill the pipe, then order is preserved.
        load_centre(8'd0, 8'd0);
        seen_x.delete(); seen_y.delete();
        bp_x[0] = 8'd1; bp_x[1] = 8'd2; bp_x[2] = 8'd3; bp_x[3] = 8'd4;
        bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b1; bus.YREL = 8'd0;
        bus.XREL = bp_x[0]; step(acc); check("bp_acc0", 32'(acc), 32'd1);
        bus.XREL = bp_x[1]; step(acc); check("bp_acc1", 32'(acc), 32'd1);
        check("bp_in_ready_low", 32'(bus.IN_READY), 32'd0);
        bus.XREL = bp_x[2]; step(acc); check("bp_acc2_blocked", 32'(acc), 32'd0);
        check("bp_out_valid", 32'(bus.OUT_VALID), 32'd1);
        check("bp_in_ready_still_low", 32'(bus.IN_READY), 32'd0);
        bus.OUT_READY = 1'b1;
        idx = 2; n = 0;
        while (idx < 4 && n < 20) begin
            bus.XREL = bp_x[idx];
            step(acc);
            if (acc) idx++;
            n++;
        end
        check("bp_all_accepted", 32'(idx), 32'd4);
        drain("bp");
        check("bp_count", 32'(seen_x.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen_x.size()) check("bp_order", 32'(seen_x[i]), 32'(bp_x[i]));
        end

        // Centre load in the same cycle as an accepted sample.
        seen_x.delete(); seen_y.delete();
        bus.CTR_LD = 1'b1; bus.XCENTER = 8'd10; bus.YCENTER = 8'd10;
        bus.IN_VALID = 1'b1; bus.XREL = 8'd1; bus.YREL = 8'd1;
        step(acc); check("ctr_acc0", 32'(acc), 32'd1);
        bus.CTR_LD = 1'b0;
        step(acc); check("ctr_acc1", 32'(acc), 32'd1);
        drain("ctr");
        check("ctr_count", 32'(seen_x.size()), 32'd2);
        if (seen_x.size() == 2) begin
            check("ctr_first_x", 32'(seen_x[0]), 32'd1);
            check("ctr_first_y", 32'(seen_y[0]), 32'd1);
            check("ctr_second_x", 32'(seen_x[1]), 32'd11);
            check("ctr_second_y", 32'(seen_y[1]), 32'd11);
        end

        // Reset with two samples in flight.
        bus.OUT_READY = 1'b0; bus.IN_VALID = 1'b1; bus.XREL = 8'd7; bus.YREL = 8'd7;
        step(acc); step(acc);
        bus.IN_VALID = 1'b0;
        check("pre_rst_full", 32'(bus.OUT_VALID), 32'd1);
        reset_pulse();
        bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1; bus.XREL = 8'd3; bus.YREL = 8'd4;
        step(acc); check("post_rst_acc", 32'(acc), 32'd1);
        bus.IN_VALID = 1'b0;
        expect_out("post_rst", 8'd3, 8'd4, 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            bus.ENB       = ($urandom_range(0, 9) != 0);
            bus.IN_VALID  = $urandom_range(0, 1);
            bus.OUT_READY = ($urandom_range(0, 3) != 0);
            bus.CTR_LD    = ($urandom_range(0, 11) == 0);
            bus.XCENTER   = 8'($urandom);
            bus.YCENTER   = 8'($urandom);
            bus.XREL      = 8'($urandom);
            bus.YREL      = 8'($urandom);
            step(acc);
        end
        drain("rand");

        // Counter wrap: stream at full rate until PT_CNT rolls over.
        bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1; bus.ENB = 1'b1; bus.CTR_LD = 1'b0;
        n = 0;
        while (mcnt != 16'hFFFF && n < 70000) begin
            bus.XREL = 8'($urandom); bus.YREL = 8'($urandom);
            step(acc);
            n++;
        end
        check("wrap_reached", 32'(bus.PT_CNT), 32'h0000FFFF);
        step(acc);
        check("wrap_to_zero", 32'(bus.PT_CNT), 32'd0);
        drain("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
